// File: rtl/ram_pkg.sv
// Shared RAM8x8 definitions: macro geometry and the BIST controller state encoding.
package ram_pkg;

    localparam int RAM_AW = 3;
    localparam int RAM_DW = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        W_ASC  = 3'd1,
        RW_RD  = 3'd2,
        RW_WR  = 3'd3,
        R_DESC = 3'd4,
        DONE   = 3'd5
    } bist_state_t;

endpackage

// File: rtl/ram_bist_ctrl_if.sv
// RAM macro port bundle (addr, D, we, Q) between the BIST controller and a 1RW RAM.
interface ram_bist_ctrl_if #(
    parameter int AW = 3,
    parameter int DW = 8
);
    // No handshake: the RAM writes ram_d to ram_addr at the clock edge when ram_we=1,
    // and ram_q is a combinational read of ram_addr, valid in the same cycle.
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_d;
    logic          ram_we;
    logic [DW-1:0] ram_q;

    modport master (output ram_addr, output ram_d, output ram_we, input ram_q);
    modport slave  (input ram_addr, input ram_d, input ram_we, output ram_q);
endinterface

// File: rtl/ram_bist_addr_gen.sv
// Up/down address counter for the march, with synchronous load and terminal-count flag.
module ram_bist_addr_gen #(
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          en,
    input  logic          up,
    output logic [AW-1:0] addr,
    output logic          tc
);
    logic [AW-1:0] addr_q, addr_d;

    always_comb begin
        addr_d = addr_q;
        if (load) begin
            addr_d = load_val;
        end else if (en) begin
            addr_d = up ? addr_q + 1'b1 : addr_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) addr_q <= '0;
        else     addr_q <= addr_d;
    end

    assign addr = addr_q;
    // Terminal count is direction dependent: top word going up, word 0 going down.
    assign tc   = up ? (addr_q == {AW{1'b1}}) : (addr_q == '0);
endmodule

// File: rtl/ram_bist_ctrl.sv
// March BIST initiator for a 1RW RAM: write P up, read-P/write-~P up, read-~P down.
// Optional feature macro: BIST_CONT_ON_FAIL_EN (run to completion and count every mismatch).
module ram_bist_ctrl
    import ram_pkg::*;
#(
    parameter int            AW      = RAM_AW,
    parameter int            DW      = RAM_DW,
    parameter logic [DW-1:0] PATTERN = 8'hA5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    ram_bist_ctrl_if.master        ram,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [AW-1:0]          fail_addr,
    output logic [DW-1:0]          fail_data,
`ifdef BIST_CONT_ON_FAIL_EN
    output logic [AW+1:0]          err_cnt,
`endif
    output bist_state_t            state_dbg
);
    bist_state_t   state_q, state_d;
    logic          cnt_load, cnt_en, cnt_up, cnt_tc;
    logic [AW-1:0] cnt_addr;
    logic          cmp_en, mismatch, start_ok;
    logic [DW-1:0] exp_data;
    logic          fail_seen_q, fail_seen_d;
    logic [AW-1:0] fail_addr_q, fail_addr_d;
    logic [DW-1:0] fail_data_q, fail_data_d;
    logic [AW+1:0] err_cnt_q, err_cnt_d;

    ram_bist_addr_gen #(.AW(AW)) u_addr_gen (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val ('0),
        .en       (cnt_en),
        .up       (cnt_up),
        .addr     (cnt_addr),
        .tc       (cnt_tc)
    );

    assign start_ok = start && (state_q == IDLE || state_q == DONE);
    assign mismatch = cmp_en && (ram.ram_q != exp_data);

    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_up   = 1'b1;
        cmp_en   = 1'b0;
        exp_data = PATTERN;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = W_ASC;
                    cnt_load = 1'b1;
                end
            end
            W_ASC: begin
                cnt_en = 1'b1;
                if (cnt_tc) state_d = RW_RD;
            end
            RW_RD: begin
                cmp_en  = 1'b1;
                state_d = RW_WR;
            end
            RW_WR: begin
                // Last RW word holds its address: R_DESC starts at the same top word.
                if (cnt_tc) begin
                    state_d = R_DESC;
                end else begin
                    cnt_en  = 1'b1;
                    state_d = RW_RD;
                end
            end
            R_DESC: begin
                cmp_en   = 1'b1;
                exp_data = ~PATTERN;
                cnt_up   = 1'b0;
                cnt_en   = 1'b1;
                if (cnt_tc) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
`ifndef BIST_CONT_ON_FAIL_EN
        if (mismatch) state_d = DONE;
`endif
    end

    always_comb begin
        fail_seen_d = fail_seen_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        err_cnt_d   = err_cnt_q;
        if (start_ok) begin
            fail_seen_d = 1'b0;
            fail_addr_d = '0;
            fail_data_d = '0;
            err_cnt_d   = '0;
        end else if (mismatch) begin
            if (!fail_seen_q) begin
                fail_seen_d = 1'b1;
                fail_addr_d = cnt_addr;
                fail_data_d = ram.ram_q;
            end
            if (err_cnt_q != {(AW+2){1'b1}}) err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            fail_seen_q <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            fail_seen_q <= fail_seen_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign busy         = (state_q != IDLE) && (state_q != DONE);
    assign done         = (state_q == DONE);
    assign pass         = done && !fail_seen_q;
    assign fail_addr    = fail_addr_q;
    assign fail_data    = fail_data_q;
    assign state_dbg    = state_q;
    assign ram.ram_addr = busy ? cnt_addr : '0;
    assign ram.ram_we   = (state_q == W_ASC) || (state_q == RW_WR);
    assign ram.ram_d    = (state_q == W_ASC) ? PATTERN :
                          (state_q == RW_WR) ? ~PATTERN : '0;
`ifdef BIST_CONT_ON_FAIL_EN
    assign err_cnt      = err_cnt_q;
`endif
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench for ram_bist_ctrl: RAM8x8 model with injectable stuck-at bits, vector table, sequence scoreboard.
module tb_ram_bist_ctrl;
    import ram_pkg::*;

    typedef struct {
        logic [2:0] sa0_a;
        logic [7:0] sa0_m;
        logic [2:0] sa1_a;
        logic [7:0] sa1_m;
        int         restart_at;
        logic       exp_pass;
        logic [2:0] exp_fa;
        logic [7:0] exp_fd;
        int         exp_cyc;
        int         exp_err;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, pass;
    logic [2:0]  fail_addr;
    logic [7:0]  fail_data;
    bist_state_t state_dbg;
`ifdef BIST_CONT_ON_FAIL_EN
    logic [4:0]  err_cnt;
`endif

    logic [7:0]  mem [8];
    logic [2:0]  sa0_a = '0, sa1_a = '0;
    logic [7:0]  sa0_m = '0, sa1_m = '0;
    int          wr_cnt = 0;
    int          checks = 0;
    int          failures = 0;
    logic [11:0] exp_q[$];
    vec_t        vecs[5];

    ram_bist_ctrl_if #(.AW(3), .DW(8)) rif();

    ram_bist_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .ram       (rif.master),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_addr (fail_addr),
        .fail_data (fail_data),
`ifdef BIST_CONT_ON_FAIL_EN
        .err_cnt   (err_cnt),
`endif
        .state_dbg (state_dbg)
    );

    always #10 clk = ~clk;

    // RAM8x8 model: synchronous write, combinational read with stuck-at masks applied.
    assign rif.ram_q = (mem[rif.ram_addr] & ~((rif.ram_addr == sa0_a) ? sa0_m : 8'h00))
                     | ((rif.ram_addr == sa1_a) ? sa1_m : 8'h00);

    always @(posedge clk) begin
        if (rif.ram_we) begin
            mem[rif.ram_addr] <= rif.ram_d;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected {addr, we, d} for cycle i of a fault-free march.
    function automatic logic [11:0] exp_seq(input int i);
        int j;
        logic [2:0] a;
        if (i < 8) begin
            a = i[2:0];
            return {a, 1'b1, 8'hA5};
        end else if (i < 24) begin
            j = i - 8;
            a = j[3:1];
            return j[0] ? {a, 1'b1, 8'h5A} : {a, 1'b0, 8'h00};
        end
        j = 31 - i;
        a = j[2:0];
        return {a, 1'b0, 8'h00};
    endfunction

    task automatic run_vec(input int k, input vec_t v);
        int   cyc;
        logic both;
        logic [11:0] e;
        sa0_a = v.sa0_a; sa0_m = v.sa0_m;
        sa1_a = v.sa1_a; sa1_m = v.sa1_m;
        exp_q.delete();
        for (int i = 0; i < v.exp_cyc; i++) exp_q.push_back(exp_seq(i));
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk($sformatf("v%0d_cleared", k), {done, pass, fail_addr, fail_data}, 32'h0);
`ifdef BIST_CONT_ON_FAIL_EN
        chk($sformatf("v%0d_err_cleared", k), err_cnt, 32'h0);
`endif
        cyc  = 0;
        both = 1'b0;
        while (!done && cyc < 200) begin
            if (busy && done) both = 1'b1;
            if (busy) begin
                cyc++;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk($sformatf("v%0d_seq%0d", k, cyc), {rif.ram_addr, rif.ram_we, rif.ram_d}, e);
                end
            end
            start = (cyc == v.restart_at);
            @(negedge clk);
        end
        start = 1'b0;
        chk($sformatf("v%0d_done_timeout", k), done, 1'b1);
        chk($sformatf("v%0d_busy_cycles", k), cyc, v.exp_cyc);
        chk($sformatf("v%0d_busy_done_excl", k), {both, busy}, 32'h0);
        chk($sformatf("v%0d_seq_left", k), exp_q.size(), 32'h0);
        chk($sformatf("v%0d_pass", k), pass, v.exp_pass);
        chk($sformatf("v%0d_fail_addr", k), fail_addr, v.exp_fa);
        chk($sformatf("v%0d_fail_data", k), fail_data, v.exp_fd);
        chk($sformatf("v%0d_idle_ram", k), {rif.ram_we, rif.ram_d}, 32'h0);
`ifdef BIST_CONT_ON_FAIL_EN
        chk($sformatf("v%0d_err_cnt", k), err_cnt, v.exp_err);
`endif
        repeat (3) @(negedge clk);
        chk($sformatf("v%0d_done_held", k), {done, state_dbg}, {1'b1, DONE});
    endtask

    initial begin
        int wr_snap;
        logic cont;
`ifdef BIST_CONT_ON_FAIL_EN
        cont = 1'b1;
`else
        cont = 1'b0;
`endif
        for (int i = 0; i < 8; i++) mem[i] = 8'h00;
        vecs[0] = '{3'd0, 8'h00, 3'd0, 8'h00, -1, 1'b1, 3'd0, 8'h00, 32, 0};
        vecs[1] = '{3'd5, 8'h08, 3'd0, 8'h00, -1, 1'b0, 3'd5, 8'h52, cont ? 32 : 27, 1};
        vecs[2] = '{3'd5, 8'h08, 3'd2, 8'h02, -1, 1'b0, 3'd2, 8'hA7, cont ? 32 : 13, 2};
        vecs[3] = '{3'd0, 8'h00, 3'd0, 8'h00, 10, 1'b1, 3'd0, 8'h00, 32, 0};
        vecs[4] = '{3'd5, 8'h00, 3'd0, 8'h80, -1, 1'b0, 3'd0, 8'hDA, 32, 1};

        // Reset values, then a reset that aborts a running test.
        repeat (3) @(negedge clk);
        chk("rst_outputs", {busy, done, pass, fail_addr, fail_data}, 32'h0);
        chk("rst_ram", {rif.ram_addr, rif.ram_we, rif.ram_d}, 32'h0);
        chk("rst_state", state_dbg, IDLE);
        rst = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (9) @(negedge clk);
        chk("mid_busy", busy, 1'b1);
        #3 rst = 1'b1;
        #1;
        chk("abort_outputs", {busy, done, pass, fail_addr, fail_data}, 32'h0);
        chk("abort_ram", {rif.ram_addr, rif.ram_we, rif.ram_d}, 32'h0);
        chk("abort_state", state_dbg, IDLE);
        wr_snap = wr_cnt;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        chk("abort_no_writes", wr_cnt, wr_snap);
        chk("abort_still_idle", {busy, done, state_dbg}, {2'b00, IDLE});

        for (int k = 0; k < 5; k++) begin
            run_vec(k, vecs[k]);
            if (k == 0) begin
                for (int i = 0; i < 8; i++) chk($sformatf("ram_word%0d", i), mem[i], 8'h5A);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
